// File: rtl/fifo_wptr_full.sv
// ============================================================================
// Module   : fifo_wptr_full
// Purpose  : Write-domain pointer, full/almost-full/overflow flags and fill
//            level for an asynchronous FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_wptr_full #(
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_THRESH = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  winc,
  input  logic [ADDR_WIDTH:0]   rptr_sync,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr,
  output logic                  wfull,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wlevel,
  output logic                  overflow
);

  localparam int              PW             = ADDR_WIDTH + 1;
  localparam logic [PW-1:0]   c_afull_thresh = PW'(AFULL_THRESH);

  logic [PW-1:0] r_wbin;
  logic [PW-1:0] w_wbin_next;
  logic [PW-1:0] w_wgray_next;
  logic [PW-1:0] w_rbin_s;
  logic [PW-1:0] w_level_next;
  logic [PW-1:0] w_full_ptr;
  logic          w_full_next;

  assign wr_en        = winc & ~wfull;
  assign w_wbin_next  = r_wbin + {{ADDR_WIDTH{1'b0}}, wr_en};
  assign w_wgray_next = (w_wbin_next >> 1) ^ w_wbin_next;

  // Gray-to-binary of the synchronized read pointer: XOR prefix from the MSB.
  for (genvar i = 0; i < PW; i++) begin : g_gray2bin
    assign w_rbin_s[i] = ^rptr_sync[PW-1:i];
  end

  assign w_level_next = w_wbin_next - w_rbin_s;

  // Full when the write Gray pointer equals the read pointer with its top two
  // bits inverted; stays in the Gray domain so no write-side conversion.
  assign w_full_ptr  = {~rptr_sync[PW-1:PW-2], rptr_sync[PW-3:0]};
  assign w_full_next = (w_wgray_next == w_full_ptr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wbin      <= '0;
      wptr        <= '0;
      waddr       <= '0;
      wfull       <= 1'b0;
      almost_full <= 1'b0;
      wlevel      <= '0;
      overflow    <= 1'b0;
    end else begin
      r_wbin      <= w_wbin_next;
      wptr        <= w_wgray_next;
      waddr       <= w_wbin_next[ADDR_WIDTH-1:0];
      wfull       <= w_full_next;
      almost_full <= (w_level_next >= c_afull_thresh);
      wlevel      <= w_level_next;
      overflow    <= overflow | (winc & wfull);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_wptr_full.sv
// ============================================================================
// Module   : tb_fifo_wptr_full
// Purpose  : Self-checking bench for fifo_wptr_full (ADDR_WIDTH=4, THRESH=14).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_wptr_full;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          winc;
  logic [AW:0]   rptr_sync;
  logic          wr_en;
  logic [AW-1:0] waddr;
  logic [AW:0]   wptr;
  logic          wfull;
  logic          almost_full;
  logic [AW:0]   wlevel;
  logic          overflow;

  fifo_wptr_full #(.ADDR_WIDTH(AW), .AFULL_THRESH(14)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .winc       (winc),
    .rptr_sync  (rptr_sync),
    .wr_en      (wr_en),
    .waddr      (waddr),
    .wptr       (wptr),
    .wfull      (wfull),
    .almost_full(almost_full),
    .wlevel     (wlevel),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: counts of words written/read; occupancy is their difference.
  logic [AW:0] m_w, m_r, m_lvl;
  logic        m_full, m_af, m_ovf;

  typedef struct {
    logic        winc;
    logic [AW:0] rbin;
    logic        full;
    logic        af;
    logic [AW:0] lvl;
    logic        ovf;
    logic [AW:0] wptr;
  } vec_t;

  vec_t tv[$];

  function automatic logic [AW:0] gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("wptr",        32'(wptr),        32'(gray(m_w)));
    chk("waddr",       32'(waddr),       32'(m_w[AW-1:0]));
    chk("wfull",       32'(wfull),       32'(m_full));
    chk("almost_full", 32'(almost_full), 32'(m_af));
    chk("wlevel",      32'(wlevel),      32'(m_lvl));
    chk("overflow",    32'(overflow),    32'(m_ovf));
  endtask

  task automatic model_reset();
    m_w = '0; m_r = '0; m_lvl = '0;
    m_full = 1'b0; m_af = 1'b0; m_ovf = 1'b0;
  endtask

  // One write-clock cycle: drive, check strobe, advance the model, check outputs.
  task automatic cycle(input logic w, input logic [AW:0] rb);
    winc      = w;
    rptr_sync = gray(rb);
    #1;
    chk("wr_en", 32'(wr_en), 32'(w & ~m_full));
    if (w && !m_full) m_w = m_w + 1'b1;
    m_ovf = m_ovf | (w & m_full);
    m_r   = rb;
    m_lvl = m_w - m_r;
    m_full = (m_lvl == 5'd16);
    m_af   = (m_lvl >= 5'd14);
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Asynchronous reset pulse away from the clock edge, with a write pending.
  task automatic mid_reset();
    winc  = 1'b1;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("wr_en_in_reset", 32'(wr_en), 32'd1);
    winc = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    winc      = 1'b0;
    rptr_sync = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;

    // Reset mid-cycle after a few writes, then first write after release.
    for (int i = 0; i < 3; i++) cycle(1'b1, 5'd0);
    mid_reset();
    cycle(1'b1, 5'd0);
    chk("post_reset_waddr", 32'(waddr), 32'd1);
    chk("post_reset_wptr",  32'(wptr),  32'b00001);

    // Directed fill / overflow / drain table.
    mid_reset();
    for (int i = 1; i <= 16; i++)
      tv.push_back('{1'b1, 5'd0, (i == 16), (i >= 14), 5'(i), 1'b0, gray(5'(i))});
    tv.push_back('{1'b1, 5'd0, 1'b1, 1'b1, 5'd16, 1'b1, 5'b11000});
    tv.push_back('{1'b0, 5'd0, 1'b1, 1'b1, 5'd16, 1'b1, 5'b11000});
    tv.push_back('{1'b0, 5'd1, 1'b0, 1'b1, 5'd15, 1'b1, 5'b11000});
    tv.push_back('{1'b0, 5'd2, 1'b0, 1'b1, 5'd14, 1'b1, 5'b11000});
    foreach (tv[i]) begin
      cycle(tv[i].winc, tv[i].rbin);
      chk($sformatf("tv%0d_wfull", i),    32'(wfull),       32'(tv[i].full));
      chk($sformatf("tv%0d_afull", i),    32'(almost_full), 32'(tv[i].af));
      chk($sformatf("tv%0d_wlevel", i),   32'(wlevel),      32'(tv[i].lvl));
      chk($sformatf("tv%0d_overflow", i), 32'(overflow),    32'(tv[i].ovf));
      chk($sformatf("tv%0d_wptr", i),     32'(wptr),        32'(tv[i].wptr));
    end

    // Refill to full, then reset while full.
    cycle(1'b1, 5'd2);
    cycle(1'b1, 5'd2);
    chk("refill_full", 32'(wfull), 32'd1);
    mid_reset();
    chk("rst_full_wfull",  32'(wfull),    32'd0);
    chk("rst_full_ovf",    32'(overflow), 32'd0);
    chk("rst_full_wlevel", 32'(wlevel),   32'd0);
    rptr_sync = '0;
    cycle(1'b1, 5'd0);
    chk("rst_full_waddr", 32'(waddr), 32'd1);

    // Wrap: reader trails three writes behind.
    mid_reset();
    for (int n = 1; n <= 40; n++) begin
      cycle(1'b1, (n >= 3) ? 5'(n - 3) : 5'd0);
      if (n == 31) chk("wrap_wptr31", 32'(wptr), 32'b10000);
      if (n == 32) chk("wrap_wptr32", 32'(wptr), 32'b00000);
      if (n >= 3)  chk("wrap_wlevel", 32'(wlevel), 32'd3);
      chk("wrap_nofull", 32'({wfull, almost_full}), 32'd0);
    end

    // Randomized traffic against the count-based model.
    mid_reset();
    for (int i = 0; i < 400; i++) begin
      logic       w;
      logic [AW:0] rb;
      w  = ($urandom_range(0, 3) != 0);
      rb = m_r;
      if (m_lvl != 0 && $urandom_range(0, 2) == 0) rb = m_r + 1'b1;
      cycle(w, rb);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout actual=running required=finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule

`default_nettype wire
